lpc_periph_multi: RTL

LPC_PERIPH_MULTI -- requirements
Module: lpc_periph_multi

---
 rtl/lpc_periph_multi.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lpc_periph_multi.sv
// LPC peripheral target: decodes I/O (and optionally memory) cycles into up to eight address
// windows and hands each hit to a backend request/ack port. Memory cycles need LPC_PERIPH_MEM_CYCLE_EN.
module lpc_periph_multi #(
  parameter int unsigned            NUM_WIN  = 2,
  parameter logic [16*NUM_WIN-1:0]  WIN_BASE = {16'h0060, 16'h0080},
  parameter logic [16*NUM_WIN-1:0]  WIN_MASK = {16'hFFFF, 16'hFFFC},
  parameter logic [15:0]            MEM_HI   = 16'hFF00,
  parameter int unsigned            WAIT_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lframe_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  output logic [31:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_wr_o,
  output logic        bus_mem_o,
  output logic [2:0]  bus_win_o,
  output logic        bus_req_o,
  input  logic        bus_ack_i,
  input  logic [7:0]  bus_rdata_i,
  output logic        err_o,
  output logic [4:0]  state_o
);

  localparam logic [3:0] SyncLong  = 4'b0110;
  localparam logic [3:0] SyncReady = 4'b0000;
  localparam logic [3:0] SyncErr   = 4'b1010;
  localparam logic [3:0] LadIdle   = 4'b1111;
  localparam logic [7:0] WaitLast  = 8'(WAIT_MAX - 1);

  typedef enum logic [4:0] {
    StIdle    = 5'd0,
    StCycType = 5'd1,
    StAddr    = 5'd2,
    StWdata   = 5'd3,
    StTar1    = 5'd4,
    StTar2    = 5'd5,
    StSync    = 5'd6,
    StRdata   = 5'd7,
    StPtar1   = 5'd8,
    StPtar2   = 5'd9,
    StSkip    = 5'd10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lad_q, lad_d;
  logic        oe_q, oe_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  win_q, win_d;
  logic        wr_q, wr_d;
  logic        mem_q, mem_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sync_end_q, sync_end_d;

  logic [31:0] addr_shift;
  logic        hit;
  logic [2:0]  hit_idx;

  assign addr_shift = {addr_q[27:0], lad_i};

  // Scan downwards so the lowest matching window index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int k = int'(NUM_WIN) - 1; k >= 0; k--) begin
      if ((addr_shift[15:0] & WIN_MASK[16*k +: 16]) ==
          (WIN_BASE[16*k +: 16] & WIN_MASK[16*k +: 16])) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
    if (mem_q && (addr_shift[31:16] != MEM_HI)) begin
      hit = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    lad_d      = lad_q;
    oe_d       = oe_q;
    req_d      = req_q;
    err_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    win_d      = win_q;
    wr_d       = wr_q;
    mem_d      = mem_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    rdata_d    = rdata_q;
    sync_end_d = sync_end_q;

    // A low LFRAME# always means START; this covers fresh cycles, held frames and aborts alike.
    if (!lframe_i) begin
      state_d    = (lad_i == 4'b0000) ? StCycType : StSkip;
      lad_d      = LadIdle;
      oe_d       = 1'b0;
      req_d      = 1'b0;
      sync_end_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCycType: begin
          addr_d  = 32'd0;
          state_d = StSkip;
          unique case (lad_i[3:1])
            3'b000, 3'b001: begin
              wr_d    = lad_i[1];
              mem_d   = 1'b0;
              cnt_d   = 3'd3;
              state_d = StAddr;
            end
            3'b010, 3'b011: begin
`ifdef LPC_PERIPH_MEM_CYCLE_EN
              wr_d    = lad_i[1];
              mem_d   = 1'b1;
              cnt_d   = 3'd7;
              state_d = StAddr;
`else
              state_d = StSkip;
`endif
            end
            default: state_d = StSkip;
          endcase
        end
        StAddr: begin
          addr_d = addr_shift;
          if (cnt_q == 3'd0) begin
            if (hit) begin
              win_d   = hit_idx;
              state_d = wr_q ? StWdata : StTar1;
            end else begin
              state_d = StSkip;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StWdata: begin
          if (cnt_q == 3'd0) begin
            wdata_d[3:0] = lad_i;
            cnt_d        = 3'd1;
          end else begin
            wdata_d[7:4] = lad_i;
            cnt_d        = 3'd0;
            state_d      = StTar1;
          end
        end
        StTar1: state_d = StTar2;
        StTar2: begin
          state_d    = StSync;
          lad_d      = SyncLong;
          oe_d       = 1'b1;
          req_d      = 1'b1;
          wcnt_d     = 8'd0;
          sync_end_d = 1'b0;
        end
        StSync: begin
          if (sync_end_q) begin
            // Ready or error nibble has gone out; only a successful read returns data.
            sync_end_d = 1'b0;
            if (!wr_q && (lad_q == SyncReady)) begin
              state_d = StRdata;
              lad_d   = rdata_q[3:0];
              cnt_d   = 3'd0;
            end else begin
              state_d = StPtar1;
              lad_d   = LadIdle;
            end
          end else if (bus_ack_i) begin
            lad_d      = SyncReady;
            req_d      = 1'b0;
            rdata_d    = bus_rdata_i;
            sync_end_d = 1'b1;
          end else if (wcnt_q == WaitLast) begin
            lad_d      = SyncErr;
            req_d      = 1'b0;
            err_d      = 1'b1;
            sync_end_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        StRdata: begin
          if (cnt_q == 3'd0) begin
            lad_d = rdata_q[7:4];
            cnt_d = 3'd1;
          end else begin
            lad_d   = LadIdle;
            state_d = StPtar1;
          end
        end
        StPtar1: begin
          state_d = StPtar2;
          oe_d    = 1'b0;
        end
        StPtar2: state_d = StIdle;
        StSkip:  ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      lad_q      <= LadIdle;
      oe_q       <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 8'd0;
      win_q      <= 3'd0;
      wr_q       <= 1'b0;
      mem_q      <= 1'b0;
      cnt_q      <= 3'd0;
      wcnt_q     <= 8'd0;
      rdata_q    <= 8'd0;
      sync_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lad_q      <= lad_d;
      oe_q       <= oe_d;
      req_q      <= req_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      win_q      <= win_d;
      wr_q       <= wr_d;
      mem_q      <= mem_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      rdata_q    <= rdata_d;
      sync_end_q <= sync_end_d;
    end
  end

  assign lad_o       = lad_q;
  assign lad_oe_o    = oe_q;
  assign bus_req_o   = req_q;
  assign err_o       = err_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_win_o   = win_q;
  assign bus_wr_o    = wr_q;
  assign state_o     = state_q;
`ifdef LPC_PERIPH_MEM_CYCLE_EN
  assign bus_mem_o   = mem_q;
`else
  assign bus_mem_o   = 1'b0;
`endif

endmodule
